// File: rtl/mmcm_drp_sequencer_pkg.sv
// Shared definitions for the MMCM DRP reprogramming sequencer: FSM state
// encoding, register-bank offsets, the table entry layout and the
// read-modify-write merge.
package mmcm_drp_sequencer_pkg;

  typedef logic [3:0] seq_state_t;

  localparam seq_state_t ST_IDLE      = 4'd0;
  localparam seq_state_t ST_RST_ON    = 4'd1;
  localparam seq_state_t ST_RD        = 4'd2;
  localparam seq_state_t ST_RD_WAIT   = 4'd3;
  localparam seq_state_t ST_WR        = 4'd4;
  localparam seq_state_t ST_WR_WAIT   = 4'd5;
  localparam seq_state_t ST_RST_OFF   = 4'd6;
  localparam seq_state_t ST_WAIT_LOCK = 4'd7;
  localparam seq_state_t ST_ABORT     = 4'd8;

  // LOCKED may still reflect the previous configuration right after reset
  // release, so the first few synchronized samples are not trusted.
  localparam int LOCK_IGNORE_CYCLES = 4;

  // Offsets used by the USB register-bank wrapper.
  localparam logic [7:0] REG_MMCM_SEQ_TBL  = 8'h70;
  localparam logic [7:0] REG_MMCM_SEQ_CTRL = 8'h71;
  localparam logic [7:0] REG_MMCM_SEQ_STAT = 8'h72;

  // One 39-bit table entry: DRP address, preserve mask, new bit values.
  typedef struct packed {
    logic [6:0]  daddr;
    logic [15:0] mask;
    logic [15:0] data;
  } seq_entry_t;

  // Mask bit 1 keeps the readback bit, mask bit 0 takes the table bit.
  function automatic logic [15:0] rmw_merge(input logic [15:0] rd, input seq_entry_t e);
    return (rd & e.mask) | (e.data & ~e.mask);
  endfunction

endpackage

// File: rtl/mmcm_seq_table.sv
// Entry table for the DRP sequencer: one synchronous write port for the
// host, one asynchronous read port for the sequencer. Contents are not reset.
module mmcm_seq_table
  import mmcm_drp_sequencer_pkg::*;
#(
  parameter int  pNUM_ENTRIES = 8,
  localparam int IW = $clog2(pNUM_ENTRIES)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [IW-1:0] wr_idx,
  input  seq_entry_t    wr_entry,
  input  logic [IW-1:0] rd_idx,
  output seq_entry_t    rd_entry
);

  seq_entry_t mem [pNUM_ENTRIES];

  // Host writes land in any state; the sequencer does not arbitrate.
  always_ff @(posedge clk) begin
    if (we) mem[wr_idx] <= wr_entry;
  end

  assign rd_entry = mem[rd_idx];

endmodule

// File: rtl/mmcm_drp_sequencer.sv
// Atomic MMCM reprogramming: hold MMCM in reset, read-modify-write each
// table entry over DRP, release reset, then wait for a fresh LOCKED.
//
// DRP handshake: drp_den is a one-cycle request (drp_dwe qualifies it as a
// write); the access completes on the first drp_drdy seen in the matching
// wait state. No new request is issued until that completion, and a drp_drdy
// arriving outside a wait state is ignored.
module mmcm_drp_sequencer
  import mmcm_drp_sequencer_pkg::*;
#(
  parameter int  pNUM_ENTRIES  = 8,
  parameter int  pDRDY_TIMEOUT = 255,
  parameter int  pLOCK_TIMEOUT = 65535,
  localparam int IW = $clog2(pNUM_ENTRIES)
) (
  input  logic          clk_usb,
  input  logic          reset_i,
  input  logic          tbl_we,
  input  logic [IW-1:0] tbl_idx,
  input  logic [6:0]    tbl_daddr,
  input  logic [15:0]   tbl_mask,
  input  logic [15:0]   tbl_data,
  input  logic [IW:0]   num_entries,
  input  logic          start,
  output logic          busy,
  output logic          done,
  output logic          err_drdy,
  output logic          err_lock,
  output logic [6:0]    drp_addr,
  output logic          drp_den,
  output logic          drp_dwe,
  output logic [15:0]   drp_din,
  input  logic [15:0]   drp_dout,
  input  logic          drp_drdy,
  output logic          drp_reset,
  input  logic          mmcm_locked
);

  localparam int CW = IW + 1;
  localparam int DW = $clog2(pDRDY_TIMEOUT + 1);
  localparam int LW = $clog2(pLOCK_TIMEOUT + 1);

  localparam logic [CW-1:0] MAX_N       = CW'(pNUM_ENTRIES);
  localparam logic [CW-1:0] IDX_ONE     = CW'(1);
  localparam logic [DW-1:0] DRDY_LAST   = DW'(pDRDY_TIMEOUT - 1);
  localparam logic [DW-1:0] DRDY_ONE    = DW'(1);
  localparam logic [LW-1:0] LOCK_LAST   = LW'(pLOCK_TIMEOUT - 1);
  localparam logic [LW-1:0] LOCK_ONE    = LW'(1);
  localparam logic [LW-1:0] LOCK_IGNORE = LW'(LOCK_IGNORE_CYCLES);

  seq_state_t    state;
  seq_entry_t    wr_entry;
  seq_entry_t    cur_entry;
  logic [CW-1:0] idx;
  logic [CW-1:0] n_q;
  logic [CW-1:0] n_sat;
  logic [CW-1:0] idx_inc;
  logic [DW-1:0] drdy_cnt;
  logic [LW-1:0] lock_cnt;
  logic [15:0]   rmw_q;
  logic          lock_meta;
  logic          locked_sync;
  logic          in_access;

  assign wr_entry = '{daddr: tbl_daddr, mask: tbl_mask, data: tbl_data};

  mmcm_seq_table #(
    .pNUM_ENTRIES (pNUM_ENTRIES)
  ) u_table (
    .clk      (clk_usb),
    .we       (tbl_we),
    .wr_idx   (tbl_idx),
    .wr_entry (wr_entry),
    .rd_idx   (idx[IW-1:0]),
    .rd_entry (cur_entry)
  );

  assign n_sat     = (num_entries > MAX_N) ? MAX_N : num_entries;
  assign idx_inc   = idx + IDX_ONE;
  assign in_access = (state == ST_RD) || (state == ST_RD_WAIT) ||
                     (state == ST_WR) || (state == ST_WR_WAIT);

  // DRP strobes come straight from the state so reset drops them at once;
  // the address follows the current entry, which is frozen until WR_WAIT ends.
  assign drp_den  = (state == ST_RD) || (state == ST_WR);
  assign drp_dwe  = (state == ST_WR);
  assign drp_addr = in_access ? cur_entry.daddr : 7'd0;
  assign drp_din  = rmw_q;

  // Two-flop synchronizer for the asynchronous LOCKED input.
  always_ff @(posedge clk_usb) begin
    if (reset_i) begin
      lock_meta   <= 1'b0;
      locked_sync <= 1'b0;
    end else begin
      lock_meta   <= mmcm_locked;
      locked_sync <= lock_meta;
    end
  end

  // Sequencer FSM with DRDY and LOCK timeout counters.
  always_ff @(posedge clk_usb) begin
    if (reset_i) begin
      state     <= ST_IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      err_drdy  <= 1'b0;
      err_lock  <= 1'b0;
      drp_reset <= 1'b0;
      idx       <= '0;
      n_q       <= '0;
      drdy_cnt  <= '0;
      lock_cnt  <= '0;
      rmw_q     <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          // busy lingers for the done/err_lock cycle, so a start there is dropped
          if (start && !busy) begin
            err_drdy  <= 1'b0;
            err_lock  <= 1'b0;
            n_q       <= n_sat;
            idx       <= '0;
            busy      <= 1'b1;
            drp_reset <= 1'b1;
            state     <= ST_RST_ON;
          end else begin
            busy <= 1'b0;
          end
        end
        ST_RST_ON: begin
          if (n_q != '0) begin
            state <= ST_RD;
          end else begin
            drp_reset <= 1'b0;
            state     <= ST_RST_OFF;
          end
        end
        ST_RD: begin
          drdy_cnt <= '0;
          state    <= ST_RD_WAIT;
        end
        ST_RD_WAIT: begin
          if (drp_drdy) begin
            rmw_q <= rmw_merge(drp_dout, cur_entry);
            state <= ST_WR;
          end else if (drdy_cnt >= DRDY_LAST) begin
            err_drdy  <= 1'b1;
            drp_reset <= 1'b0;
            state     <= ST_ABORT;
          end else begin
            drdy_cnt <= drdy_cnt + DRDY_ONE;
          end
        end
        ST_WR: begin
          drdy_cnt <= '0;
          state    <= ST_WR_WAIT;
        end
        ST_WR_WAIT: begin
          if (drp_drdy) begin
            idx <= idx_inc;
            if (idx_inc == n_q) begin
              drp_reset <= 1'b0;
              state     <= ST_RST_OFF;
            end else begin
              state <= ST_RD;
            end
          end else if (drdy_cnt >= DRDY_LAST) begin
            err_drdy  <= 1'b1;
            drp_reset <= 1'b0;
            state     <= ST_ABORT;
          end else begin
            drdy_cnt <= drdy_cnt + DRDY_ONE;
          end
        end
        ST_RST_OFF: begin
          lock_cnt <= '0;
          state    <= ST_WAIT_LOCK;
        end
        ST_WAIT_LOCK: begin
          if ((lock_cnt >= LOCK_IGNORE) && locked_sync) begin
            done  <= 1'b1;
            state <= ST_IDLE;
          end else if (lock_cnt >= LOCK_LAST) begin
            err_lock <= 1'b1;
            state    <= ST_IDLE;
          end else begin
            lock_cnt <= lock_cnt + LOCK_ONE;
          end
        end
        ST_ABORT: begin
          // partial configuration stays in the MMCM; no done pulse
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
        default: begin
          busy      <= 1'b0;
          drp_reset <= 1'b0;
          state     <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mmcm_drp_sequencer.sv
// Directed bench for mmcm_drp_sequencer with a DRP/MMCM model.
module tb_mmcm_drp_sequencer;

  localparam int NUM = 8;
  localparam int TO  = 40;
  localparam int LTO = 300;

  typedef struct {
    int num;
    int lmode;     // 0 never locks, 1 always locked, 2 locks ldelay cycles after RST falls
    int ldelay;
    int drop_rd;   // read number (0-based) whose DRDY is withheld, -1 none
    int exp_rd;
    int exp_wr;
    bit exp_done;
    bit exp_edrdy;
    bit exp_elock;
    int tkind;     // 1 rst fall->done, 2 rst fall->err_lock, 3 last den->err_drdy
    int tmin;
    int tmax;
  } vec_t;

  // clock / reset
  logic        clk = 1'b0;
  logic        reset_i;
  always #5 clk = ~clk;

  logic        tbl_we;
  logic [2:0]  tbl_idx;
  logic [6:0]  tbl_daddr;
  logic [15:0] tbl_mask;
  logic [15:0] tbl_data;
  logic [3:0]  num_entries;
  logic        start;
  logic        busy, done, err_drdy, err_lock;
  logic [6:0]  drp_addr;
  logic        drp_den, drp_dwe;
  logic [15:0] drp_din;
  logic [15:0] drp_dout;
  logic        drp_drdy;
  logic        drp_reset;
  logic        mmcm_locked;

  mmcm_drp_sequencer #(
    .pNUM_ENTRIES  (NUM),
    .pDRDY_TIMEOUT (TO),
    .pLOCK_TIMEOUT (LTO)
  ) dut (
    .clk_usb     (clk),
    .reset_i     (reset_i),
    .tbl_we      (tbl_we),
    .tbl_idx     (tbl_idx),
    .tbl_daddr   (tbl_daddr),
    .tbl_mask    (tbl_mask),
    .tbl_data    (tbl_data),
    .num_entries (num_entries),
    .start       (start),
    .busy        (busy),
    .done        (done),
    .err_drdy    (err_drdy),
    .err_lock    (err_lock),
    .drp_addr    (drp_addr),
    .drp_den     (drp_den),
    .drp_dwe     (drp_dwe),
    .drp_din     (drp_din),
    .drp_dout    (drp_dout),
    .drp_drdy    (drp_drdy),
    .drp_reset   (drp_reset),
    .mmcm_locked (mmcm_locked)
  );

  // scoreboard
  int n_checks = 0;
  int n_fail   = 0;
  logic [22:0] exp_q[$];     // {addr, din} of expected writes, in order
  logic [6:0]  exp_rd_q[$];  // addresses of expected reads, in order

  logic [6:0]  t_addr  [NUM];
  logic [15:0] t_mask  [NUM];
  logic [15:0] t_data  [NUM];
  logic [15:0] t_init  [NUM];
  logic [15:0] t_wdata [NUM];
  vec_t        vecs    [8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_rng(input string name, input int val, input int lo, input int hi);
    n_checks++;
    if (val < lo || val > hi) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d..%0d", name, val, lo, hi);
    end
  endtask

  // DRP model: DO returns the stored register, DRDY 3 cycles after DEN
  logic [15:0] model_reg [128];
  int          cd = 0;
  bit          pend_rd, pend_drop;
  logic [6:0]  pend_addr;
  int          rd_cnt = 0;
  int          drop_rd = -1;
  logic [22:0] exp_w;
  logic [6:0]  exp_a;

  always @(negedge clk) begin
    drp_drdy = 1'b0;
    if (reset_i) begin
      cd = 0;
    end else begin
      if (cd > 0) begin
        cd--;
        if (cd == 0 && !pend_drop) begin
          drp_drdy = 1'b1;
          drp_dout = pend_rd ? model_reg[pend_addr] : 16'h0;
        end
      end
      if (drp_den) begin
        chk("den_while_pending", cd, 0);
        chk("rst_high_at_den", {31'd0, drp_reset}, 1);
        if (drp_dwe) begin
          model_reg[drp_addr] = drp_din;
          chk("write_expected", {31'd0, exp_q.size() != 0}, 1);
          if (exp_q.size() != 0) begin
            exp_w = exp_q.pop_front();
            chk("write_addr_data", {9'd0, drp_addr, drp_din}, {9'd0, exp_w});
          end
          pend_rd   = 1'b0;
          pend_drop = 1'b0;
        end else begin
          chk("read_expected", {31'd0, exp_rd_q.size() != 0}, 1);
          if (exp_rd_q.size() != 0) begin
            exp_a = exp_rd_q.pop_front();
            chk("read_addr", {25'd0, drp_addr}, {25'd0, exp_a});
          end
          pend_drop = (rd_cnt == drop_rd);
          rd_cnt++;
          pend_rd = 1'b1;
        end
        pend_addr = drp_addr;
        cd = 3;
      end
    end
  end

  // MMCM LOCKED model
  int lock_mode  = 2;
  int lock_delay = 20;
  int rst_low_cnt = 0;
  always @(negedge clk) begin
    if (drp_reset) rst_low_cnt = 0;
    else if (rst_low_cnt < 100000) rst_low_cnt++;
    case (lock_mode)
      0:       mmcm_locked = 1'b0;
      1:       mmcm_locked = 1'b1;
      default: mmcm_locked = (rst_low_cnt >= lock_delay);
    endcase
  end

  // event monitor
  int cyc = 0;
  bit prev_rst = 1'b0, prev_edrdy = 1'b0, prev_elock = 1'b0;
  int rst_fall_t, done_t, edrdy_t, elock_t, last_den_t;
  int done_cnt = 0;
  always @(negedge clk) begin
    cyc++;
    if (prev_rst && !drp_reset) rst_fall_t = cyc;
    if (drp_den) last_den_t = cyc;
    if (done) begin
      done_cnt++;
      done_t = cyc;
      chk("busy_with_done", {31'd0, busy}, 1);
    end
    if (err_drdy && !prev_edrdy) edrdy_t = cyc;
    if (err_lock && !prev_elock) elock_t = cyc;
    prev_rst   = drp_reset;
    prev_edrdy = err_drdy;
    prev_elock = err_lock;
  end

  // driver tasks
  task automatic prep(input vec_t v);
    for (int i = 0; i < 128; i++) model_reg[i] = 16'h0;
    for (int i = 0; i < NUM; i++) model_reg[t_addr[i]] = t_init[i];
    lock_mode  = v.lmode;
    lock_delay = v.ldelay;
    drop_rd    = v.drop_rd;
    rd_cnt     = 0;
    exp_q.delete();
    exp_rd_q.delete();
    for (int i = 0; i < v.exp_wr; i++) exp_q.push_back({t_addr[i], t_wdata[i]});
    for (int i = 0; i < v.exp_rd; i++) exp_rd_q.push_back(t_addr[i]);
    done_cnt   = 0;
    rst_fall_t = -100000;
    done_t     = 100000;
    edrdy_t    = 100000;
    elock_t    = 100000;
    last_den_t = -100000;
    @(negedge clk);
  endtask

  task automatic pulse_start(input int num);
    num_entries = 4'(num);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int k = 0;
    while (busy && k < budget) begin
      @(negedge clk);
      k++;
    end
    chk("busy_drops_in_budget", {31'd0, busy}, 0);
    repeat (2) @(negedge clk);
  endtask

  task automatic verify(input vec_t v);
    chk("done_count", done_cnt, {31'd0, v.exp_done});
    chk("err_drdy", {31'd0, err_drdy}, {31'd0, v.exp_edrdy});
    chk("err_lock", {31'd0, err_lock}, {31'd0, v.exp_elock});
    chk("writes_left", exp_q.size(), 0);
    chk("reads_left", exp_rd_q.size(), 0);
    chk("drp_reset_end", {31'd0, drp_reset}, 0);
    case (v.tkind)
      1: chk_rng("t_rstoff_to_done", done_t - rst_fall_t, v.tmin, v.tmax);
      2: chk_rng("t_rstoff_to_err_lock", elock_t - rst_fall_t, v.tmin, v.tmax);
      3: chk_rng("t_den_to_err_drdy", edrdy_t - last_den_t, v.tmin, v.tmax);
      default: ;
    endcase
  endtask

  task automatic run_vec(input vec_t v);
    prep(v);
    pulse_start(v.num);
    chk("busy_after_start", {31'd0, busy}, 1);
    wait_idle(3000);
    verify(v);
  endtask

  initial begin
    vec_t h;
    int nw;

    // table contents, model initial values and hand-computed merged writes
    t_addr[0] = 7'h08; t_mask[0] = 16'hF000; t_data[0] = 16'h0145; t_init[0] = 16'hA000; t_wdata[0] = 16'hA145;
    t_addr[1] = 7'h09; t_mask[1] = 16'h00FF; t_data[1] = 16'h1234; t_init[1] = 16'hABCD; t_wdata[1] = 16'h12CD;
    t_addr[2] = 7'h0A; t_mask[2] = 16'h0000; t_data[2] = 16'hBEEF; t_init[2] = 16'h5555; t_wdata[2] = 16'hBEEF;
    t_addr[3] = 7'h0B; t_mask[3] = 16'hFFFF; t_data[3] = 16'h0000; t_init[3] = 16'h7E81; t_wdata[3] = 16'h7E81;
    t_addr[4] = 7'h14; t_mask[4] = 16'h0F0F; t_data[4] = 16'hF0F0; t_init[4] = 16'h1234; t_wdata[4] = 16'hF2F4;
    t_addr[5] = 7'h15; t_mask[5] = 16'hFF00; t_data[5] = 16'h00AA; t_init[5] = 16'h3C3C; t_wdata[5] = 16'h3CAA;
    t_addr[6] = 7'h16; t_mask[6] = 16'h8001; t_data[6] = 16'h7FFE; t_init[6] = 16'h0001; t_wdata[6] = 16'h7FFF;
    t_addr[7] = 7'h4E; t_mask[7] = 16'h5555; t_data[7] = 16'h2222; t_init[7] = 16'hFFFF; t_wdata[7] = 16'h7777;

    //                num lm dly drop rd wr done edr elk tk  tmin     tmax
    vecs[0] = '{1,  2, 20, -1, 1, 1, 1'b1, 1'b0, 1'b0, 1, 20,     24};
    vecs[1] = '{3,  2, 20, -1, 3, 3, 1'b1, 1'b0, 1'b0, 1, 20,     24};
    vecs[2] = '{3,  2, 20,  1, 2, 1, 1'b0, 1'b1, 1'b0, 3, TO,     TO + 2};
    vecs[3] = '{2,  0,  0, -1, 2, 2, 1'b0, 1'b0, 1'b1, 2, LTO,    LTO + 2};
    vecs[4] = '{2,  1,  0, -1, 2, 2, 1'b1, 1'b0, 1'b0, 1, 4,      10};
    vecs[5] = '{0,  2, 10, -1, 0, 0, 1'b1, 1'b0, 1'b0, 1, 10,     14};
    vecs[6] = '{15, 2,  5, -1, 8, 8, 1'b1, 1'b0, 1'b0, 1, 5,      9};
    vecs[7] = '{8,  2,  5, -1, 8, 8, 1'b1, 1'b0, 1'b0, 1, 5,      9};

    reset_i = 1'b1;
    tbl_we = 1'b0; tbl_idx = '0; tbl_daddr = '0; tbl_mask = '0; tbl_data = '0;
    num_entries = '0; start = 1'b0; drp_dout = '0; drp_drdy = 1'b0; mmcm_locked = 1'b0;
    repeat (3) @(negedge clk);

    // reset state
    chk("rst_busy",      {31'd0, busy}, 0);
    chk("rst_done",      {31'd0, done}, 0);
    chk("rst_err_drdy",  {31'd0, err_drdy}, 0);
    chk("rst_err_lock",  {31'd0, err_lock}, 0);
    chk("rst_drp_den",   {31'd0, drp_den}, 0);
    chk("rst_drp_dwe",   {31'd0, drp_dwe}, 0);
    chk("rst_drp_reset", {31'd0, drp_reset}, 0);
    chk("rst_drp_addr",  {25'd0, drp_addr}, 0);
    chk("rst_drp_din",   {16'd0, drp_din}, 0);
    reset_i = 1'b0;
    @(negedge clk);

    for (int i = 0; i < NUM; i++) begin
      tbl_we = 1'b1; tbl_idx = 3'(i);
      tbl_daddr = t_addr[i]; tbl_mask = t_mask[i]; tbl_data = t_data[i];
      @(negedge clk);
    end
    tbl_we = 1'b0;

    for (int i = 0; i < 8; i++) run_vec(vecs[i]);

    // second start while busy is dropped: one run, one done
    h = '{2, 2, 10, -1, 2, 2, 1'b1, 1'b0, 1'b0, 1, 10, 14};
    prep(h);
    pulse_start(2);
    repeat (5) @(negedge clk);
    pulse_start(2);
    wait_idle(3000);
    verify(h);

    // reset_i in WR_WAIT of entry 1, then a normal run
    h = '{2, 2, 10, -1, 2, 2, 1'b0, 1'b0, 1'b0, 0, 0, 0};
    prep(h);
    pulse_start(2);
    nw = 0;
    for (int k = 0; k < 200 && nw < 2; k++) begin
      if (drp_dwe) nw++;
      if (nw < 2) @(negedge clk);
    end
    chk("second_write_seen", nw, 2);
    @(negedge clk);
    reset_i = 1'b1;
    @(negedge clk);
    chk("midrst_busy",      {31'd0, busy}, 0);
    chk("midrst_drp_reset", {31'd0, drp_reset}, 0);
    chk("midrst_drp_den",   {31'd0, drp_den}, 0);
    chk("midrst_writes_left", exp_q.size(), 0);
    chk("midrst_no_done", done_cnt, 0);
    reset_i = 1'b0;
    repeat (2) @(negedge clk);
    run_vec(vecs[1]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
